mem_resp: RTL and testbench
===========================

MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning: cycles from request acceptance to mem_ready (legal range 1..15).
REQ-002 SHALL have parameter ADDR_BITS, default 6, meaning: log2 of the number of 128-bit storage lines.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_read  input  1  block read request from the cache.
REQ-006 SHALL have port mem_write  input  1  block write request from the cache.
REQ-007 SHALL have port mem_addr  input  28  block address.
REQ-008 SHALL have port mem_wdata  input  128  write block data.
REQ-009 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port mem_rdata  output  128  read block data, valid only while mem_ready=1.

Function
REQ-011 SHALL hold 2^ADDR_BITS lines of 128 bits, indexed by mem_addr[ADDR_BITS-1:0]; upper address bits are ignored, so addresses alias.
REQ-012 SHALL implement the FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-013 SHALL accept a request in IDLE on any edge where mem_read or mem_write is 1, capturing the operation, the address and mem_wdata, and loading the latency counter.
REQ-014 SHALL treat mem_read=mem_write=1 as a write.
REQ-015 SHALL ignore mem_read and mem_write while in BUSY or RESP; the requester is not required to hold the request after acceptance.
REQ-016 SHALL count down in BUSY and enter RESP so that mem_ready is 1 in exactly the cycle that begins LATENCY edges after the accepting edge (LATENCY=1: the next cycle).
REQ-017 SHALL assert mem_ready for exactly one cycle (RESP), then return to IDLE.
REQ-018 SHALL drive mem_rdata to the addressed line's contents during RESP of a read; otherwise mem_rdata = 0.
REQ-019 SHALL commit a write to the line on the edge that leaves RESP; a read accepted in the following IDLE cycle returns the new data.
REQ-020 SHALL allow back-to-back requests: a request present in the cycle after RESP is accepted on that edge, giving a minimum spacing of LATENCY+1 cycles between mem_ready pulses.
REQ-021 SHALL tolerate requesters that drop the request in the mem_ready cycle; the drop has no effect.

Reset
REQ-022 SHALL, while rst_n=0 (asynchronously), force the FSM to IDLE, the counter to 0, mem_ready=0, mem_rdata=0, and all storage lines to 0.
REQ-023 SHALL abort any in-flight request on reset mid-operation: no mem_ready pulse, and a pending write is not committed.
REQ-024 SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL use macro MEM_RESP_JITTER_EN; when defined, each accepted request adds 0..3 extra BUSY cycles, equal to lfsr[1:0].
REQ-026 SHALL implement that LFSR as 8 bits, polynomial x^8+x^6+x^5+x^4+1, seed 8'h5A on reset, advancing once per accepted request after its value is sampled.
REQ-027 SHALL, when MEM_RESP_JITTER_EN is undefined, have no LFSR and a fixed latency of exactly LATENCY.

Verification
REQ-028 SHALL verify: reset, then read addr 0x0000005 -> mem_ready pulses 4 cycles after acceptance, for one cycle, with mem_rdata=0.
REQ-029 SHALL verify: write 0x0000003 with data 128'hDEAD...BEEF, then read 0x0000043 (aliases when ADDR_BITS=6) -> returns 128'hDEAD...BEEF.
REQ-030 SHALL verify: mem_read held high continuously for 3 requests at LATENCY=1 -> mem_ready at cycles 1, 3, 5 after the first acceptance.
REQ-031 SHALL verify: mem_read=mem_write=1 with data 128'h1 at addr 7, then read addr 7 -> returns 128'h1.
REQ-032 SHALL verify: write addr 2, with rst_n pulsed low during BUSY -> no mem_ready pulse, and a later read of addr 2 returns 0.
REQ-033 SHALL verify, with MEM_RESP_JITTER_EN defined: the first request's latency is LATENCY+2 (seed low bits 2'b10), and all latencies stay within LATENCY..LATENCY+3.

Source files
------------

// File: rtl/mem_resp.sv
// mem_resp: 128-bit block memory responder with an IDLE -> BUSY -> RESP handshake and a fixed request latency.
// Optional build macro MEM_RESP_JITTER_EN adds 0..3 LFSR-chosen extra BUSY cycles per accepted request.
module mem_resp #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic         mem_ready,
  output logic [127:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam int         LINES = 1 << ADDR_BITS;

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic [4:0]           cnt_r;
  logic [4:0]           cnt_nxt_s;
  logic                 op_write_r;
  logic [ADDR_BITS-1:0] addr_r;
  logic [127:0]         wdata_r;
  logic [127:0]         mem_r [LINES];
  logic                 accept_s;
  logic [1:0]           jitter_s;
  logic [4:0]           total_lat_s;
  logic [ADDR_BITS-1:0] rd_idx_s;
  logic                 rd_op_s;
  logic                 unused_addr_hi_s;

  assign accept_s    = (state_r == IDLE) && (mem_read || mem_write);
  assign total_lat_s = 5'(LATENCY) + {3'b000, jitter_s};

  if (ADDR_BITS < 28) begin : g_addr_hi
    assign unused_addr_hi_s = ^mem_addr[27:ADDR_BITS];
  end else begin : g_addr_full
    assign unused_addr_hi_s = 1'b0;
  end

`ifdef MEM_RESP_JITTER_EN
  logic [7:0] lfsr_r;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    lfsr_next = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Jitter LFSR: sampled at acceptance, then advanced once per accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= 8'h5A;
    end else if (accept_s) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign jitter_s = lfsr_r[1:0];
`else
  assign jitter_s = 2'b00;
`endif

  // Next-state and countdown; the counter holds the BUSY cycles still to go after this one
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (total_lat_s == 5'd1) begin
            state_nxt_s = RESP;
            cnt_nxt_s   = 5'd0;
          end else begin
            state_nxt_s = BUSY;
            cnt_nxt_s   = total_lat_s - 5'd2;
          end
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 5'd0;
        end
      end
      BUSY: begin
        if (cnt_r == 5'd0) begin
          state_nxt_s = RESP;
          cnt_nxt_s   = 5'd0;
        end else begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = cnt_r - 5'd1;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 5'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 5'd0;
      end
    endcase
  end

  // A one-cycle latency enters RESP straight from IDLE, before the request is captured
  always_comb begin
    rd_idx_s = addr_r;
    rd_op_s  = 1'b0;
    if (state_r == IDLE) begin
      rd_idx_s = mem_addr[ADDR_BITS-1:0];
      rd_op_s  = mem_read && !mem_write;
    end else begin
      rd_idx_s = addr_r;
      rd_op_s  = !op_write_r;
    end
  end

  // FSM state and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request capture; mem_read together with mem_write is treated as a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write_r <= 1'b0;
      addr_r     <= {ADDR_BITS{1'b0}};
      wdata_r    <= 128'd0;
    end else if (accept_s) begin
      op_write_r <= mem_write;
      addr_r     <= mem_addr[ADDR_BITS-1:0];
      wdata_r    <= mem_wdata;
    end else begin
      op_write_r <= op_write_r;
      addr_r     <= addr_r;
      wdata_r    <= wdata_r;
    end
  end

  // Registered response: ready and read data are loaded on the edge entering RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= 128'd0;
    end else if (state_nxt_s == RESP) begin
      mem_ready <= 1'b1;
      mem_rdata <= rd_op_s ? mem_r[rd_idx_s] : 128'd0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= 128'd0;
    end
  end

  // Storage: writes commit on the edge leaving RESP, so a reset before then drops them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) begin
        mem_r[i] <= 128'd0;
      end
    end else if ((state_r == RESP) && op_write_r) begin
      mem_r[addr_r] <= wdata_r;
    end else begin
      mem_r[addr_r] <= mem_r[addr_r];
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed scenarios plus randomized traffic against a line-array model.
module tb_mem_resp;

  localparam int LAT  = 4;
  localparam int LAT1 = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic         rd1, wr1;
  logic [27:0]  addr1;
  logic [127:0] wdata1;
  logic         ready1;
  logic [127:0] rdata1;

  int errors = 0;
  int checks = 0;
  logic [127:0] ref_mem [64];
  logic [7:0]   mdl_lfsr0, mdl_lfsr1;

  always #5 clk = ~clk;

  mem_resp #(.LATENCY(LAT), .ADDR_BITS(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_resp #(.LATENCY(LAT1), .ADDR_BITS(6)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_ready(ready1), .mem_rdata(rdata1)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic next_jitter(input int which, output int j);
    j = 0;
`ifdef MEM_RESP_JITTER_EN
    if (which == 0) begin
      j = int'(mdl_lfsr0[1:0]);
      mdl_lfsr0 = lfsr_step(mdl_lfsr0);
    end else begin
      j = int'(mdl_lfsr1[1:0]);
      mdl_lfsr1 = lfsr_step(mdl_lfsr1);
    end
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = 28'd0; mem_wdata = 128'd0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 28'd0; wdata1 = 128'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 128'd0;
    mdl_lfsr0 = 8'h5A;
    mdl_lfsr1 = 8'h5A;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issue one request on the main DUT; random noise is driven on the request pins while busy
  task automatic issue(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] d,
                       output int lat, output logic [127:0] rdat, output bit leak, output bit width_ok);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
    @(posedge clk); #1;
    lat = 1;
    leak = 1'b0;
    while (mem_ready !== 1'b1 && lat < 40) begin
      if (mem_rdata !== 128'd0) leak = 1'b1;
      mem_read = 1'($urandom); mem_write = 1'($urandom); mem_addr = 28'($urandom); mem_wdata = rand128();
      @(posedge clk); #1;
      lat++;
    end
    rdat = mem_rdata;
    mem_read = 1'($urandom); mem_write = 1'($urandom); mem_addr = 28'($urandom);
    @(posedge clk); #1;
    width_ok = (mem_ready === 1'b0) && (mem_rdata === 128'd0);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %0b expected 0", mem_ready);
    end
    checks++;
    if (mem_rdata !== 128'd0) begin
      errors++; $display("FAIL reset_rdata: got %0h expected 0", mem_rdata);
    end
  endtask

  task automatic test_first_read();
    int lat, j, exp_lat;
    logic [127:0] rdat;
    bit leak, wok;
    next_jitter(0, j);
`ifdef MEM_RESP_JITTER_EN
    exp_lat = LAT + 2;
`else
    exp_lat = LAT;
`endif
    issue(1'b1, 1'b0, 28'h0000005, 128'd0, lat, rdat, leak, wok);
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL first_read_latency: got %0d expected %0d", lat, exp_lat);
    end
    checks++;
    if (rdat !== 128'd0) begin
      errors++; $display("FAIL first_read_data: got %0h expected 0", rdat);
    end
    checks++;
    if (!wok) begin
      errors++; $display("FAIL first_read_pulse_width: got ready still high expected one cycle");
    end
    checks++;
    if (leak) begin
      errors++; $display("FAIL first_read_rdata_idle: got nonzero rdata expected 0 outside ready");
    end
  endtask

  task automatic test_alias();
    int lat, j;
    logic [127:0] rdat, pat;
    bit leak, wok;
    pat = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    next_jitter(0, j);
    issue(1'b0, 1'b1, 28'h0000003, pat, lat, rdat, leak, wok);
    ref_mem[3] = pat;
    checks++;
    if (lat != LAT + j) begin
      errors++; $display("FAIL alias_write_latency: got %0d expected %0d", lat, LAT + j);
    end
    checks++;
    if (rdat !== 128'd0) begin
      errors++; $display("FAIL alias_write_rdata: got %0h expected 0", rdat);
    end
    next_jitter(0, j);
    issue(1'b1, 1'b0, 28'h0000043, 128'd0, lat, rdat, leak, wok);
    checks++;
    if (rdat !== pat) begin
      errors++; $display("FAIL alias_read_data: got %0h expected %0h", rdat, pat);
    end
  endtask

  task automatic test_both_is_write();
    int lat, j;
    logic [127:0] rdat;
    bit leak, wok;
    next_jitter(0, j);
    issue(1'b1, 1'b1, 28'h0000007, 128'h1, lat, rdat, leak, wok);
    ref_mem[7] = 128'h1;
    checks++;
    if (rdat !== 128'd0) begin
      errors++; $display("FAIL both_rdata: got %0h expected 0", rdat);
    end
    next_jitter(0, j);
    issue(1'b1, 1'b0, 28'h0000007, 128'd0, lat, rdat, leak, wok);
    checks++;
    if (rdat !== 128'h1) begin
      errors++; $display("FAIL both_read_back: got %0h expected 1", rdat);
    end
  endtask

  task automatic test_back_to_back();
    int exp_t[3];
    int got_t[3];
    int n, j, t, extra;
    t = 0;
    for (int k = 0; k < 3; k++) begin
      next_jitter(1, j);
      t = (k == 0) ? (LAT1 + j) : (t + 1 + LAT1 + j);
      exp_t[k] = t;
      got_t[k] = -1;
    end
    n = 0;
    extra = 0;
    rd1 = 1'b1; addr1 = 28'h0000009;
    @(posedge clk); #1;
    for (int c = 1; c <= 30; c++) begin
      if (ready1 === 1'b1) begin
        if (n < 3) got_t[n] = c;
        else extra++;
        n++;
        if (n == 3) rd1 = 1'b0;
      end
      @(posedge clk); #1;
    end
    rd1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_t[k] != exp_t[k]) begin
        errors++; $display("FAIL b2b_ready_cycle%0d: got %0d expected %0d", k, got_t[k], exp_t[k]);
      end
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL b2b_extra_pulses: got %0d expected 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int seen, lat, j;
    logic [127:0] rdat;
    bit leak, wok;
    next_jitter(0, j);
    mem_read = 1'b0; mem_write = 1'b1; mem_addr = 28'h0000002; mem_wdata = 128'hCAFE_F00D;
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 128'd0;
    mdl_lfsr0 = 8'h5A;
    mdl_lfsr1 = 8'h5A;
    #2 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_no_ready: got %0d pulses expected 0", seen);
    end
    next_jitter(0, j);
    issue(1'b1, 1'b0, 28'h0000002, 128'd0, lat, rdat, leak, wok);
    checks++;
    if (rdat !== 128'd0) begin
      errors++; $display("FAIL abort_write_dropped: got %0h expected 0", rdat);
    end
    checks++;
    if (lat != LAT + j) begin
      errors++; $display("FAIL abort_reread_latency: got %0d expected %0d", lat, LAT + j);
    end
  endtask

  task automatic test_random();
    int lat, j, kind, idx;
    logic [27:0]  a;
    logic [127:0] d, rdat, exp_d;
    bit leak, wok;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a = {22'($urandom), 3'b000, 3'($urandom_range(0, 7))};
      d = rand128();
      idx = int'(a[5:0]);
      next_jitter(0, j);
      exp_d = (kind == 0) ? ref_mem[idx] : 128'd0;
      issue(kind != 1, kind != 0, a, d, lat, rdat, leak, wok);
      if (kind != 0) ref_mem[idx] = d;
      checks++;
      if (rdat !== exp_d) begin
        errors++; $display("FAIL rand_data[%0d]: got %0h expected %0h", n, rdat, exp_d);
      end
      checks++;
      if (lat != LAT + j || lat < LAT || lat > LAT + 3) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, LAT + j);
      end
      checks++;
      if (!wok || leak) begin
        errors++; $display("FAIL rand_pulse[%0d]: got width_ok=%0b leak=%0b expected 1 0", n, wok, leak);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_alias();
    test_both_is_write();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
